// File: rtl/ifetch_unit_if.sv
// Fetch-stage bus: instruction-memory port, execute redirect and the decode handshake.
// "slave" is the fetch unit's view; "master" is its surroundings (memory, execute, decode).
interface ifetch_unit_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_rd;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;
    logic        fetch_err;

    modport slave (
        output imem_addr,
        input  imem_rd,
        input  redirect_valid,
        input  redirect_pc,
        input  out_ready,
        output out_valid,
        output out_instr,
        output out_pc,
        output out_pc_plus4,
        output fetch_err
    );

    modport master (
        input  imem_addr,
        output imem_rd,
        output redirect_valid,
        output redirect_pc,
        output out_ready,
        input  out_valid,
        input  out_instr,
        input  out_pc,
        input  out_pc_plus4,
        input  fetch_err
    );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch: owns the PC, reads a combinational instruction memory and queues
// {instr, pc} pairs in a small prefetch buffer feeding decode over valid/ready.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          DEPTH      = 2,
    parameter int          IMEM_WORDS = 64
) (
    input  logic          clk,
    input  logic          reset,
    ifetch_unit_if.slave  bus
);
    localparam int          PW        = $clog2(DEPTH);
    localparam logic [PW:0] CNT_FULL  = (PW+1)'(DEPTH);
    localparam logic [29:0] IMEM_LIM  = 30'(IMEM_WORDS);

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_buf_instr [DEPTH];
    logic [31:0]   r_buf_pc    [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [PW:0]   r_count;
    logic          r_fetch_err;

    logic w_in_range;
    logic w_pop;
    logic w_push;
    logic w_aligned;

    assign w_in_range = (r_fetch_pc[31:2] < IMEM_LIM);
    assign w_aligned  = (bus.redirect_pc[1:0] == 2'b00);
    assign w_pop      = bus.out_valid & bus.out_ready;
    // Full buffer may still accept a word when the head leaves in the same cycle.
    assign w_push     = !bus.redirect_valid & !r_fetch_err & w_in_range
                      & ((r_count < CNT_FULL) | w_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_pc  <= RESET_PC;
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_fetch_err <= 1'b0;
        end else if (bus.redirect_valid) begin
            // Flush wins over any same-cycle handshake; a misaligned target keeps the old PC.
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            if (w_aligned) begin
                r_fetch_pc  <= bus.redirect_pc;
                r_fetch_err <= 1'b0;
            end else begin
                r_fetch_err <= 1'b1;
            end
        end else begin
            if (!w_in_range) begin
                r_fetch_err <= 1'b1;
            end
            if (w_push) begin
                r_wr_ptr   <= r_wr_ptr + PW'(1);
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_buf_instr[r_wr_ptr] <= bus.imem_rd;
            r_buf_pc[r_wr_ptr]    <= r_fetch_pc;
        end
    end

    assign bus.imem_addr    = r_fetch_pc;
    assign bus.out_valid    = (r_count != '0);
    assign bus.out_instr    = r_buf_instr[r_rd_ptr];
    assign bus.out_pc       = r_buf_pc[r_rd_ptr];
    assign bus.out_pc_plus4 = r_buf_pc[r_rd_ptr] + 32'd4;
    assign bus.fetch_err    = r_fetch_err;
endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: a queue-based reference of the fetch rules, directed scenarios
// and a randomized ready/redirect run, all compared against the DUT outputs.
module tb_ifetch_unit;
    localparam int DEPTH      = 2;
    localparam int IMEM_WORDS = 64;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    ifetch_unit_if bus ();

    ifetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .DEPTH     (DEPTH),
        .IMEM_WORDS(IMEM_WORDS)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    // Memory word k holds 0x1000_0000 + k.
    assign bus.imem_rd = 32'h1000_0000 + {2'b00, bus.imem_addr[31:2]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state: queue of buffered PCs, fetch PC, sticky error.
    logic [31:0] m_q[$];
    logic [31:0] m_fp;
    logic        m_err;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return 32'h1000_0000 + (pc >> 2);
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_fp  = 32'h0;
        m_err = 1'b0;
    endtask

    // Drive one cycle of inputs, advance the reference at the edge, return #1 after it.
    task automatic cycle(input logic rdy, input logic rv, input logic [31:0] rpc);
        logic pop, push, inr;
        bus.out_ready      = rdy;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        @(posedge clk);
        if (rv) begin
            m_q.delete();
            if (rpc[1:0] == 2'b00) begin
                m_fp  = rpc;
                m_err = 1'b0;
            end else begin
                m_err = 1'b1;
            end
        end else begin
            pop  = (m_q.size() != 0) && rdy;
            inr  = (m_fp < 32'(IMEM_WORDS * 4));
            push = !m_err && inr && ((m_q.size() < DEPTH) || pop);
            if (!inr) m_err = 1'b1;
            if (pop) void'(m_q.pop_front());
            if (push) begin
                m_q.push_back(m_fp);
                m_fp = m_fp + 32'd4;
            end
        end
        #1;
        bus.redirect_valid = 1'b0;
    endtask

    task automatic do_reset();
        bus.out_ready      = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        bus.out_ready      = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        reset = 1'b1;
        #2;
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.out_valid);
        end
        n_checks++;
        if (bus.fetch_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_err: got %b expected 0", bus.fetch_err);
        end
        n_checks++;
        if (bus.imem_addr !== 32'h0) begin
            n_fail++; $display("FAIL reset_addr: got %h expected 00000000", bus.imem_addr);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_stream();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b0, 32'h0);
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'(4 * i)) begin
                n_fail++;
                $display("FAIL stream_pc[%0d]: got v=%b pc=%h expected v=1 pc=%h",
                         i, bus.out_valid, bus.out_pc, 32'(4 * i));
            end
            n_checks++;
            if (bus.out_instr !== 32'h1000_0000 + 32'(i)) begin
                n_fail++;
                $display("FAIL stream_instr[%0d]: got %h expected %h",
                         i, bus.out_instr, 32'h1000_0000 + 32'(i));
            end
            n_checks++;
            if (bus.out_pc_plus4 !== 32'(4 * i + 4)) begin
                n_fail++;
                $display("FAIL stream_plus4[%0d]: got %h expected %h",
                         i, bus.out_pc_plus4, 32'(4 * i + 4));
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 32'h0);
        n_checks++;
        if (bus.imem_addr !== 32'h8) begin
            n_fail++; $display("FAIL stall_addr: got %h expected 00000008", bus.imem_addr);
        end
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL stall_head: got v=%b pc=%h expected v=1 pc=00000000",
                     bus.out_valid, bus.out_pc);
        end
        for (int i = 1; i <= 3; i++) begin
            cycle(1'b1, 1'b0, 32'h0);
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'(4 * i)) begin
                n_fail++;
                $display("FAIL stall_release[%0d]: got v=%b pc=%h expected v=1 pc=%h",
                         i, bus.out_valid, bus.out_pc, 32'(4 * i));
            end
        end
    endtask

    task automatic test_redirect();
        do_reset();
        cycle(1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 32'h0);
        n_checks++;
        if (bus.out_pc !== 32'h4) begin
            n_fail++; $display("FAIL redir_pre: got %h expected 00000004", bus.out_pc);
        end
        cycle(1'b1, 1'b1, 32'h40);
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.imem_addr !== 32'h40) begin
            n_fail++;
            $display("FAIL redir_flush: got v=%b addr=%h expected v=0 addr=00000040",
                     bus.out_valid, bus.imem_addr);
        end
        cycle(1'b1, 1'b0, 32'h0);
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h40 || bus.out_instr !== 32'h1000_0010) begin
            n_fail++;
            $display("FAIL redir_target: got v=%b pc=%h instr=%h expected v=1 pc=00000040 instr=10000010",
                     bus.out_valid, bus.out_pc, bus.out_instr);
        end
        cycle(1'b1, 1'b0, 32'h0);
        n_checks++;
        if (bus.out_pc !== 32'h44) begin
            n_fail++; $display("FAIL redir_next: got %h expected 00000044", bus.out_pc);
        end
    endtask

    task automatic test_misaligned();
        logic [31:0] held;
        held = m_fp;
        cycle(1'b1, 1'b1, 32'h22);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (bus.fetch_err !== 1'b1 || bus.out_valid !== 1'b0 || bus.imem_addr !== held) begin
                n_fail++;
                $display("FAIL misalign_hold[%0d]: got err=%b v=%b addr=%h expected err=1 v=0 addr=%h",
                         i, bus.fetch_err, bus.out_valid, bus.imem_addr, held);
            end
            cycle(1'b1, 1'b0, 32'h0);
        end
        cycle(1'b1, 1'b1, 32'h10);
        n_checks++;
        if (bus.fetch_err !== 1'b0 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL misalign_clear: got err=%b v=%b expected err=0 v=0",
                     bus.fetch_err, bus.out_valid);
        end
        cycle(1'b1, 1'b0, 32'h0);
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h10) begin
            n_fail++;
            $display("FAIL misalign_resume: got v=%b pc=%h expected v=1 pc=00000010",
                     bus.out_valid, bus.out_pc);
        end
    endtask

    task automatic test_range_end();
        do_reset();
        cycle(1'b0, 1'b1, 32'hF8);
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        n_checks++;
        if (bus.imem_addr !== 32'h100 || bus.fetch_err !== 1'b0) begin
            n_fail++;
            $display("FAIL range_edge: got addr=%h err=%b expected addr=00000100 err=0",
                     bus.imem_addr, bus.fetch_err);
        end
        cycle(1'b0, 1'b0, 32'h0);
        n_checks++;
        if (bus.fetch_err !== 1'b1 || bus.out_valid !== 1'b1 || bus.out_pc !== 32'hF8) begin
            n_fail++;
            $display("FAIL range_err: got err=%b v=%b pc=%h expected err=1 v=1 pc=000000f8",
                     bus.fetch_err, bus.out_valid, bus.out_pc);
        end
        cycle(1'b1, 1'b0, 32'h0);
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'hFC || bus.out_instr !== 32'h1000_003F) begin
            n_fail++;
            $display("FAIL range_drain: got v=%b pc=%h instr=%h expected v=1 pc=000000fc instr=1000003f",
                     bus.out_valid, bus.out_pc, bus.out_instr);
        end
        cycle(1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 32'h0);
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.fetch_err !== 1'b1 || bus.imem_addr !== 32'h100) begin
            n_fail++;
            $display("FAIL range_halt: got v=%b err=%b addr=%h expected v=0 err=1 addr=00000100",
                     bus.out_valid, bus.fetch_err, bus.imem_addr);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0);
        #3;
        reset = 1'b1;
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.imem_addr !== 32'h0 || bus.fetch_err !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got v=%b addr=%h err=%b expected v=0 addr=00000000 err=0",
                     bus.out_valid, bus.imem_addr, bus.fetch_err);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, 1'b0, 32'h0);
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'(4 * i)
                || bus.out_instr !== 32'h1000_0000 + 32'(i)) begin
                n_fail++;
                $display("FAIL wrap_stream[%0d]: got v=%b pc=%h instr=%h expected pc=%h",
                         i, bus.out_valid, bus.out_pc, bus.out_instr, 32'(4 * i));
            end
        end
    endtask

    task automatic test_random();
        logic        rdy, rv;
        logic [31:0] rpc;
        logic        exp_v;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rdy = ($urandom_range(0, 3) != 0);
            rv  = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 3))
                0:       rpc = {24'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(1, 3))};
                1:       rpc = 32'hF0;
                default: rpc = {22'h0, 8'($urandom_range(0, 70)), 2'b00};
            endcase
            cycle(rdy, rv, rpc);
            exp_v = (m_q.size() != 0);
            n_checks++;
            if (bus.out_valid !== exp_v) begin
                n_fail++;
                $display("FAIL rand_valid[%0d]: got %b expected %b", i, bus.out_valid, exp_v);
            end
            n_checks++;
            if (bus.imem_addr !== m_fp || bus.fetch_err !== m_err) begin
                n_fail++;
                $display("FAIL rand_fetch[%0d]: got addr=%h err=%b expected addr=%h err=%b",
                         i, bus.imem_addr, bus.fetch_err, m_fp, m_err);
            end
            if (exp_v) begin
                n_checks++;
                if (bus.out_pc !== m_q[0] || bus.out_instr !== instr_of(m_q[0])
                    || bus.out_pc_plus4 !== m_q[0] + 32'd4) begin
                    n_fail++;
                    $display("FAIL rand_head[%0d]: got pc=%h instr=%h p4=%h expected pc=%h instr=%h",
                             i, bus.out_pc, bus.out_instr, bus.out_pc_plus4, m_q[0], instr_of(m_q[0]));
                end
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        model_reset();
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_misaligned();
        test_range_end();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
